// File: rtl/eth_tx_sched_pkg.sv
// Shared types and constants for the 10BASE-T transmit-line scheduler.
package eth_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IPG     = 3'd1,
    FRM_ARM = 3'd2,
    FRM     = 3'd3,
    LP_ARM  = 3'd4,
    LP      = 3'd5
  } sched_state_t;

  localparam logic [1:0] TXSEL_QUIET = 2'd0;
  localparam logic [1:0] TXSEL_LP    = 2'd1;
  localparam logic [1:0] TXSEL_FRM   = 2'd2;

  localparam int LP_PERIOD_16MS = 320000;
  localparam int IPG_9U6        = 192;

  function automatic logic [1:0] txsel_of(sched_state_t s);
    case (s)
      FRM_ARM, FRM: return TXSEL_FRM;
      LP_ARM, LP:   return TXSEL_LP;
      default:      return TXSEL_QUIET;
    endcase
  endfunction

endpackage

// File: rtl/eth_tx_sched_if.sv
// Handshake bundle between the scheduler, the transmit top level and the two line drivers.
interface eth_tx_sched_if;
  logic       frm_req;
  logic       frm_go;
  logic       frm_busy;
  logic       lp_go;
  logic       lp_busy;
  logic [1:0] tx_sel;
  logic       Led_Tx;
  logic       wdog_err;

  modport master (
    input  frm_req, frm_busy, lp_busy,
    output frm_go, lp_go, tx_sel, Led_Tx, wdog_err
  );

  modport slave (
    output frm_req, frm_busy, lp_busy,
    input  frm_go, lp_go, tx_sel, Led_Tx, wdog_err
  );
endinterface

// File: rtl/eth_ivl_timer.sv
// Saturating up-counter with synchronous clear, enable and a terminal-count flag.
module eth_ivl_timer #(
  parameter int MAX = 8,
  parameter int TC  = MAX - 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] TC_V  = W'(TC);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (clr)                  cnt <= '0;
    else if (en && cnt != MAX_V)   cnt <= cnt + 1'b1;
  end

  assign tc = en && (cnt == TC_V);
endmodule

// File: rtl/eth_tx_sched.sv
// Transmit-line scheduler: arbitrates the twisted-pair output between frame serializer and link pulses.
// Define ETH_TX_SCHED_WDOG_EN to time out ARM states whose busy never rises.
//
// state   | meaning
// IDLE    | line quiet and gap satisfied; grant a frame or a due link pulse
// IPG     | inter-packet gap running after line activity
// FRM_ARM | frm_go issued, waiting for frm_busy
// FRM     | serializer owns the line
// LP_ARM  | lp_go issued, waiting for lp_busy
// LP      | link-pulse generator owns the line
module eth_tx_sched
  import eth_tx_pkg::*;
#(
  parameter int LP_PERIOD = LP_PERIOD_16MS,
  parameter int IPG_CYC   = IPG_9U6,
  parameter int WDOG_CYC  = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  eth_tx_sched_if.master bus
);
`ifdef ETH_TX_SCHED_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  sched_state_t state, state_nx;
  logic         frm_go_q, lp_go_q, led_q;
  logic [1:0]   tx_sel_q;
  logic         frm_go_nx, lp_go_nx, led_nx;
  logic [1:0]   tx_sel_nx;
  logic         lp_due, gap_done, wdog_to, in_arm;

  assign in_arm = (state == FRM_ARM) || (state == LP_ARM);

  // lp_cnt advances only once the gap is done, so link-pulse spacing runs from the end of activity
  eth_ivl_timer #(.MAX(LP_PERIOD), .TC(LP_PERIOD - 1)) u_lp_cnt (
    .clk, .rst_n,
    .clr ((state != IDLE) || bus.frm_req),
    .en  (state == IDLE),
    .tc  (lp_due)
  );

  eth_ivl_timer #(.MAX(IPG_CYC), .TC(IPG_CYC - 1)) u_gap_cnt (
    .clk, .rst_n,
    .clr (state != IPG),
    .en  (state == IPG),
    .tc  (gap_done)
  );

  eth_ivl_timer #(.MAX(WDOG_CYC), .TC(WDOG_CYC - 1)) u_wdog_cnt (
    .clk, .rst_n,
    .clr (!in_arm),
    .en  (WDOG_EN && in_arm),
    .tc  (wdog_to)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IPG;
      frm_go_q <= 1'b0;
      lp_go_q  <= 1'b0;
      tx_sel_q <= TXSEL_QUIET;
      led_q    <= 1'b1;
    end else begin
      state    <= state_nx;
      frm_go_q <= frm_go_nx;
      lp_go_q  <= lp_go_nx;
      tx_sel_q <= tx_sel_nx;
      led_q    <= led_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.frm_req)     state_nx = FRM_ARM;
               else if (lp_due)     state_nx = LP_ARM;
      IPG:     if (gap_done)        state_nx = IDLE;
      FRM_ARM: if (bus.frm_busy)    state_nx = FRM;
               else if (wdog_to)    state_nx = IPG;
      FRM:     if (!bus.frm_busy)   state_nx = IPG;
      LP_ARM:  if (bus.lp_busy)     state_nx = LP;
               else if (wdog_to)    state_nx = IPG;
      LP:      if (!bus.lp_busy)    state_nx = IPG;
      default:                      state_nx = IPG;
    endcase
  end

  always_comb begin
    frm_go_nx = (state == IDLE) && (state_nx == FRM_ARM);
    lp_go_nx  = (state == IDLE) && (state_nx == LP_ARM);
    tx_sel_nx = txsel_of(state_nx);
    led_nx    = (state_nx != FRM);
  end

  assign bus.frm_go = frm_go_q;
  assign bus.lp_go  = lp_go_q;
  assign bus.tx_sel = tx_sel_q;
  assign bus.Led_Tx = led_q;

`ifdef ETH_TX_SCHED_WDOG_EN
  logic wdog_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         wdog_err_q <= 1'b0;
    else if (in_arm && state_nx == IPG) wdog_err_q <= 1'b1;
  end

  assign bus.wdog_err = wdog_err_q;
`else
  assign bus.wdog_err = 1'b0;
`endif
endmodule

// File: tb/tb_eth_tx_sched.sv
// Self-checking bench for eth_tx_sched: directed vector table, corner sequences, randomized run vs timeline model.
module tb_eth_tx_sched;
  localparam int LP  = 1000;
  localparam int IPG = 8;
  localparam int WD  = 4;
`ifdef ETH_TX_SCHED_WDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  eth_tx_sched_if bus();

  eth_tx_sched #(.LP_PERIOD(LP), .IPG_CYC(IPG), .WDOG_CYC(WD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req;
    logic       fb;
    logic       lb;
    logic [1:0] sel;
    logic       fgo;
    logic       lgo;
    logic       led;
  } vec_t;

  vec_t tbl[$];

  int n_cmp = 0;
  int n_bad = 0;
  int lp_seen = 0;

  // timeline model: who owns the line, whether its busy has been seen, when the line went quiet
  int cyc, t_quiet, t_arm, owner;
  bit active, m_err, m_fgo, m_lgo;

  int f_dly = 0, f_len = 0, l_dly = 0, l_len = 0, req_odds = 60;

  function automatic vec_t mk(bit req, bit fb, bit lb, int sel, bit fgo, bit lgo, bit led);
    vec_t v;
    v.req = req; v.fb = fb; v.lb = lb; v.sel = sel[1:0];
    v.fgo = fgo; v.lgo = lgo; v.led = led;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  function automatic void model_reset();
    cyc = 0; t_quiet = 0; t_arm = 0; owner = 0;
    active = 0; m_err = 0; m_fgo = 0; m_lgo = 0;
  endfunction

  function automatic void model_edge();
    bit busy;
    cyc++;
    m_fgo = 0;
    m_lgo = 0;
    busy = (owner == 2) ? bus.frm_busy : bus.lp_busy;
    if (owner == 0) begin
      if (cyc - t_quiet > IPG) begin
        if (bus.frm_req) begin
          owner = 2; active = 0; t_arm = cyc; m_fgo = 1;
        end else if (cyc - t_quiet >= IPG + LP) begin
          owner = 1; active = 0; t_arm = cyc; m_lgo = 1;
        end
      end
    end else if (!active) begin
      if (busy) active = 1;
      else if (WD_ON && (cyc - t_arm >= WD)) begin
        owner = 0; t_quiet = cyc; m_err = 1;
      end
    end else if (!busy) begin
      owner = 0; active = 0; t_quiet = cyc;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    chk("outputs", {bus.frm_go, bus.lp_go, bus.tx_sel, bus.Led_Tx, bus.wdog_err},
        {m_fgo, m_lgo, owner[1:0], ~(owner == 2 && active), m_err & WD_ON});
    if (bus.lp_go === 1'b1) lp_seen++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.frm_req = 0; bus.frm_busy = 0; bus.lp_busy = 0;
    f_dly = 0; f_len = 0; l_dly = 0; l_len = 0;
    model_reset();
    #1;
    chk("rst_tx_sel", bus.tx_sel, 0);
    chk("rst_led", bus.Led_Tx, 1);
    chk("rst_go_err", {bus.frm_go, bus.lp_go, bus.wdog_err}, 0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_go(input bit frm, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if ((frm ? bus.frm_go : bus.lp_go) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic scen_first_lp();
    int at, f;
    wait_go(1'b0, IPG + LP + 50, at);
    chk("first_lp_at", at, IPG + LP);
    step();
    bus.lp_busy = 1;
    repeat (20) step();
    bus.lp_busy = 0;
    step();
    f = cyc;
    wait_go(1'b0, IPG + LP + 50, at);
    chk("lp_spacing", at - f, IPG + LP);
  endtask

  function automatic void rand_drive();
    if (m_fgo) begin
      bus.frm_req = 0;
      f_dly = $urandom_range(0, 5);
      f_len = $urandom_range(1, 40);
    end else if (!bus.frm_req && $urandom_range(0, req_odds - 1) == 0) begin
      bus.frm_req = 1;
    end
    if (m_lgo) begin
      l_dly = $urandom_range(0, 5);
      l_len = $urandom_range(1, 30);
    end
    if (f_dly > 0)      begin f_dly--; bus.frm_busy = 0; end
    else if (f_len > 0) begin f_len--; bus.frm_busy = 1; end
    else                bus.frm_busy = ($urandom_range(0, 31) == 0);
    if (l_dly > 0)      begin l_dly--; bus.lp_busy = 0; end
    else if (l_len > 0) begin l_len--; bus.lp_busy = 1; end
    else                bus.lp_busy = ($urandom_range(0, 31) == 0);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish (cycle %0d)", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int at, f, lp0, led_low, sel_frm;

    for (int k = 1; k <= 8; k++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 2, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 2, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1));
    for (int k = 15; k <= 21; k++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 2, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 2, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1));

    bus.frm_req = 0; bus.frm_busy = 0; bus.lp_busy = 0;
    model_reset();

    // directed vectors from reset release
    do_reset();
    foreach (tbl[i]) begin
      bus.frm_req  = tbl[i].req;
      bus.frm_busy = tbl[i].fb;
      bus.lp_busy  = tbl[i].lb;
      step();
      chk($sformatf("vec%0d", i + 1), {bus.tx_sel, bus.frm_go, bus.lp_go, bus.Led_Tx},
          {tbl[i].sel, tbl[i].fgo, tbl[i].lgo, tbl[i].led});
    end
    bus.frm_req = 0; bus.frm_busy = 0; bus.lp_busy = 0;

    // first link pulse after reset and spacing from lp_busy fall
    do_reset();
    scen_first_lp();

    // frame request lands on the cycle the link pulse falls due
    step();
    bus.lp_busy = 1;
    repeat (5) step();
    bus.lp_busy = 0;
    step();
    f = cyc;
    for (int i = 0; i < IPG + LP + 10 && cyc < f + IPG + LP - 1; i++) step();
    bus.frm_req = 1;
    step();
    chk("collide_frm_go", bus.frm_go, 1);
    chk("collide_lp_go", bus.lp_go, 0);
    bus.frm_req = 0;
    step();
    bus.frm_busy = 1;
    led_low = 0;
    sel_frm = 0;
    repeat (100) begin
      step();
      if (bus.Led_Tx === 1'b0) led_low++;
      if (bus.tx_sel === 2'd2) sel_frm++;
    end
    bus.frm_busy = 0;
    step();
    f = cyc;
    chk("frm_end_sel", bus.tx_sel, 0);
    chk("frm_led_low", led_low, 100);
    chk("frm_sel_frm", sel_frm, 100);
    wait_go(1'b0, IPG + LP + 50, at);
    chk("lp_after_frm", at - f, IPG + LP);

    // back-to-back frames with frm_req held
    do_reset();
    lp0 = lp_seen;
    bus.frm_req = 1;
    wait_go(1'b1, 50, at);
    chk("b2b_first_go", at, IPG + 1);
    for (int n = 0; n < 3; n++) begin
      step();
      bus.frm_busy = 1;
      repeat (100) step();
      bus.frm_busy = 0;
      step();
      f = cyc;
      wait_go(1'b1, 50, at);
      chk($sformatf("b2b_gap%0d", n), at - f, IPG + 1);
    end
    chk("b2b_no_lp", lp_seen - lp0, 0);

    // asynchronous reset mid-frame
    step();
    bus.frm_busy = 1;
    repeat (10) step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_tx_sel", bus.tx_sel, 0);
    chk("async_led", bus.Led_Tx, 1);
    bus.frm_req = 0; bus.frm_busy = 0;
    step();
    step();
    rst_n = 1'b1;
    scen_first_lp();

    // busy never rises after frm_go
    do_reset();
    bus.frm_req = 1;
    wait_go(1'b1, 50, at);
    bus.frm_req = 0;
    repeat (WD) step();
    chk("wdog_tx_sel", bus.tx_sel, WD_ON ? 0 : 2);
    chk("wdog_err", bus.wdog_err, WD_ON);
    repeat (30) step();
    chk("wdog_sticky", bus.wdog_err, WD_ON);

    // randomized traffic against the timeline model
    do_reset();
    req_odds = 60;
    repeat (8000) begin rand_drive(); step(); end
    req_odds = 4000;
    repeat (8000) begin rand_drive(); step(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
